b128to32_ser: RTL and testbench

- Downstream companion to the 32-to-128 word assembler in the 32-bit-optimised datapath.
- Takes a 128-bit block from the 128-bit stage and replays it as four 32-bit words, each tagged with a 2-bit index `nr`.
- Word order and `nr` numbering mirror the assembler, so assembler -> 128-bit stage -> serializer round-trips words unchanged.
- A one-block holding buffer lets the next block be accepted while the current one drains, giving gap-free streaming.

---
 rtl/b128to32_ser.sv | 171 +++++++++++++++++
 tb/tb_b128to32_ser.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/b128to32_ser.sv
// -----------------------------------------------------------------------------
// b128to32_ser
//
// Replays a 128-bit block as four 32-bit words tagged with a 2-bit index nr.
// This is the downstream partner of the 32-to-128 word assembler. Word order
// and nr numbering match the assembler, so a round trip through the 128-bit
// stage returns the original words unchanged.
//
// One holding block ("pending") can be accepted while the active block
// drains. The pending block is then promoted on the edge that sends the last
// word, so back-to-back blocks stream at one word per cycle with no gap.
//
// Parameters
//   MSW_FIRST  1: nr 0 carries dataIn[127:96] and nr 3 carries dataIn[31:0]
//              0: nr 0 carries dataIn[31:0] and nr 3 carries dataIn[127:96]
//
// Ports
//   clock      rising-edge clock, the only clock
//   reset      synchronous reset, active low
//   enable     global advance qualifier; nothing moves on either side while low
//   in_valid   dataIn holds a block
//   in_ready   block slot available (registered, equals !pend_full)
//   dataIn     block to serialise
//   out_valid  dataOut / nr are valid
//   out_ready  consumer accepts the current word
//   dataOut    current word, selected from the active block by nr
//   nr         index of the current word, 0..3
//   last       out_valid and nr == 3
//   busy       out_valid or a pending block is held
//
// State | meaning
//   IDLE  | no word on the output; an accepted block loads active directly
//   DRAIN | out_valid high; words of the active block are sent in nr order
// -----------------------------------------------------------------------------
module b128to32_ser #(
  parameter int MSW_FIRST = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] dataIn,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  dataOut,
  output logic [1:0]   nr,
  output logic         last,
  output logic         busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t       state_q, state_nxt;
  logic [127:0] active_q, active_nxt;
  logic [127:0] pend_q, pend_nxt;
  logic         pend_full_q, pend_full_nxt;
  logic [1:0]   nr_q, nr_nxt;
  logic         in_ready_q;

  logic         accept;
  logic         xfer;
  logic         final_xfer;
  logic [1:0]   slice;

  // in_ready comes straight from a flop, so accept has no combinational
  // dependence on out_ready.
  assign accept     = in_valid & in_ready_q & enable;
  assign xfer       = (state_q == S_DRAIN) & out_ready & enable;
  assign final_xfer = xfer & (nr_q == 2'd3);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      nr_q        <= 2'd0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      active_q    <= active_nxt;
      pend_q      <= pend_nxt;
      pend_full_q <= pend_full_nxt;
      nr_q        <= nr_nxt;
      // Looks ahead at the next pend_full, so in_ready drops on the same
      // edge that fills the pending slot.
      in_ready_q  <= ~pend_full_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state_q;
    active_nxt    = active_q;
    pend_nxt      = pend_q;
    pend_full_nxt = pend_full_q;
    nr_nxt        = nr_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          active_nxt = dataIn;
          nr_nxt     = 2'd0;
          state_nxt  = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (final_xfer) begin
          nr_nxt = 2'd0;
          if (pend_full_q) begin
            // pend_full forces in_ready low, so no accept can collide here.
            active_nxt    = pend_q;
            pend_full_nxt = 1'b0;
          end else if (accept) begin
            // The new block skips pending and goes straight to active.
            active_nxt = dataIn;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          if (xfer) begin
            nr_nxt = nr_q + 2'd1;
          end
          if (accept) begin
            pend_nxt      = dataIn;
            pend_full_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output word select
  // ---------------------------------------------------------------------------
  // slice is the 32-bit lane of active_q, with lane 0 = [31:0]. With
  // MSW_FIRST, nr 0 maps to lane 3, which is the bitwise inverse of nr.
  assign slice = (MSW_FIRST != 0) ? ~nr_q : nr_q;

  always_comb begin
    dataOut = active_q[31:0];
    unique case (slice)
      2'd0:    dataOut = active_q[31:0];
      2'd1:    dataOut = active_q[63:32];
      2'd2:    dataOut = active_q[95:64];
      2'd3:    dataOut = active_q[127:96];
      default: dataOut = active_q[31:0];
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == S_DRAIN);
  assign nr        = nr_q;
  assign last      = (state_q == S_DRAIN) & (nr_q == 2'd3);
  assign busy      = (state_q == S_DRAIN) | pend_full_q;

endmodule

// File: tb/tb_b128to32_ser.sv
// -----------------------------------------------------------------------------
// tb_b128to32_ser
//
// Drives two serializers with the same stimulus, one per MSW_FIRST setting.
// A queue-based model holds the accepted blocks, with at most two held at a
// time. The head block is the one on the output, and a word index selects
// its current word. The DUT outputs are compared against this model on every
// falling edge.
//
// Directed sequences pin the model to literal words and nr values. A long
// randomized run with occasional resets follows.
// -----------------------------------------------------------------------------
module tb_b128to32_ser;

  logic         clock;
  logic         reset;
  logic         enable;
  logic         in_valid;
  logic [127:0] dataIn;
  logic         out_ready;

  logic         in_ready1, out_valid1, last1, busy1;
  logic [31:0]  dataOut1;
  logic [1:0]   nr1;
  logic         in_ready0, out_valid0, last0, busy0;
  logic [31:0]  dataOut0;
  logic [1:0]   nr0;

  int n_tests = 0;
  int n_fail  = 0;

  b128to32_ser #(.MSW_FIRST(1)) dut1 (
    .clock(clock), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready1), .dataIn(dataIn),
    .out_valid(out_valid1), .out_ready(out_ready), .dataOut(dataOut1),
    .nr(nr1), .last(last1), .busy(busy1)
  );

  b128to32_ser #(.MSW_FIRST(0)) dut0 (
    .clock(clock), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready0), .dataIn(dataIn),
    .out_valid(out_valid0), .out_ready(out_ready), .dataOut(dataOut0),
    .nr(nr0), .last(last0), .busy(busy0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cmp(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [127:0] q[$];
  int           widx = 0;
  bit           m_rdy = 1'b0;
  bit           chk = 1'b0;

  function automatic logic [31:0] word_of(input logic [127:0] blk, input int idx, input bit msw);
    logic [127:0] s;
    s = msw ? (blk >> (96 - 32 * idx)) : (blk >> (32 * idx));
    return s[31:0];
  endfunction

  always @(posedge clock) begin
    bit acc, xf;
    if (!reset) begin
      q.delete();
      widx  = 0;
      m_rdy = 1'b0;
      chk   = 1'b1;
    end else begin
      acc = in_valid && m_rdy && enable;
      xf  = (q.size() > 0) && out_ready && enable;
      if (xf) begin
        if (widx == 3) begin
          void'(q.pop_front());
          widx = 0;
        end else begin
          widx++;
        end
      end
      if (acc) q.push_back(dataIn);
      m_rdy = (q.size() < 2);
    end
  end

  task automatic check_one(input string tag, input bit msw,
                           input logic rdy, input logic vld, input logic [31:0] dout,
                           input logic [1:0] n, input logic lst, input logic bsy);
    bit mv;
    mv = (q.size() > 0);
    cmp({tag, ".in_ready"},  128'(rdy), 128'(m_rdy));
    cmp({tag, ".out_valid"}, 128'(vld), 128'(mv));
    cmp({tag, ".busy"},      128'(bsy), 128'(mv));
    cmp({tag, ".last"},      128'(lst), 128'(mv && widx == 3));
    if (mv) begin
      cmp({tag, ".nr"},      128'(n),    128'(widx));
      cmp({tag, ".dataOut"}, 128'(dout), 128'(word_of(q[0], widx, msw)));
    end
  endtask

  always @(negedge clock) begin
    if (chk) begin
      check_one("m1", 1'b1, in_ready1, out_valid1, dataOut1, nr1, last1, busy1);
      check_one("m0", 1'b0, in_ready0, out_valid0, dataOut0, nr0, last0, busy0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus and literal checks
  // ---------------------------------------------------------------------------
  logic [127:0] vec_a = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  logic [127:0] vec_b = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
  logic [127:0] vec_c = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
  logic [31:0]  wa[4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};

  initial begin
    reset     = 1'b0;
    enable    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dataIn    = '0;

    // Reset values
    @(negedge clock);
    @(negedge clock);
    cmp("rst.out_valid", 128'(out_valid1), 128'(0));
    cmp("rst.in_ready",  128'(in_ready1),  128'(0));
    cmp("rst.busy",      128'(busy1),      128'(0));
    cmp("rst.dataOut",   128'(dataOut1),   128'(0));
    cmp("rst.nr",        128'(nr1),        128'(0));
    cmp("rst.last",      128'(last1),      128'(0));
    reset = 1'b1;
    @(negedge clock);
    cmp("rel.in_ready", 128'(in_ready1), 128'(1));

    // Single block with both word orders
    in_valid = 1'b1; dataIn = vec_a;
    @(negedge clock);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cmp("single.valid",  128'(out_valid1), 128'(1));
      cmp("single.nr",     128'(nr1),        128'(k));
      cmp("single.msw1",   128'(dataOut1),   128'(wa[k]));
      cmp("single.msw0",   128'(dataOut0),   128'(wa[3-k]));
      cmp("single.last",   128'(last1),      128'(k == 3));
      @(negedge clock);
    end
    cmp("single.idle", 128'(out_valid1), 128'(0));

    // Back-to-back blocks
    in_valid = 1'b1; dataIn = vec_a;
    @(negedge clock);
    dataIn = vec_b;
    for (int k = 1; k <= 8; k++) begin
      cmp("b2b.valid", 128'(out_valid1), 128'(1));
      cmp("b2b.nr",    128'(nr1),        128'((k - 1) % 4));
      if (k == 2) cmp("b2b.in_ready_low",  128'(in_ready1), 128'(0));
      if (k == 5) begin
        cmp("b2b.in_ready_back", 128'(in_ready1), 128'(1));
        cmp("b2b.b_word0",       128'(dataOut1),  128'(32'hB0B1B2B3));
      end
      @(negedge clock);
      in_valid = 1'b0;
    end
    cmp("b2b.idle", 128'(out_valid1), 128'(0));

    // Backpressure at nr = 2
    in_valid = 1'b1; dataIn = vec_a;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cmp("bp.nr",   128'(nr1),      128'(2));
      cmp("bp.word", 128'(dataOut1), 128'(wa[2]));
      @(negedge clock);
    end
    out_ready = 1'b1;
    cmp("bp.resume2", 128'(dataOut1), 128'(wa[2]));
    @(negedge clock);
    cmp("bp.resume3", 128'(dataOut1), 128'(wa[3]));
    @(negedge clock);
    cmp("bp.idle", 128'(out_valid1), 128'(0));

    // enable low mid-block with a block on offer
    in_valid = 1'b1; dataIn = vec_a;
    @(negedge clock);
    dataIn = vec_b;
    enable = 1'b0;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    cmp("en.nr_hold",   128'(nr1),       128'(0));
    cmp("en.no_accept", 128'(in_ready1), 128'(1));
    enable = 1'b1; in_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clock);
      cmp("en.nr_seq", 128'(nr1), 128'(k));
    end
    @(negedge clock);
    cmp("en.idle", 128'(out_valid1), 128'(0));

    // Reset with a block pending at nr = 1
    in_valid = 1'b1; dataIn = vec_a;
    @(negedge clock);
    dataIn = vec_b;
    @(negedge clock);
    in_valid = 1'b0;
    cmp("mrst.pre_nr",   128'(nr1),       128'(1));
    cmp("mrst.pre_rdy",  128'(in_ready1), 128'(0));
    reset = 1'b0;
    @(negedge clock);
    cmp("mrst.valid",    128'(out_valid1), 128'(0));
    cmp("mrst.busy",     128'(busy1),      128'(0));
    cmp("mrst.in_ready", 128'(in_ready1),  128'(0));
    reset = 1'b1;
    @(negedge clock);
    cmp("mrst.rel_rdy", 128'(in_ready1), 128'(1));
    in_valid = 1'b1; dataIn = vec_c;
    @(negedge clock);
    in_valid = 1'b0;
    cmp("mrst.c_nr",   128'(nr1),      128'(0));
    cmp("mrst.c_msw1", 128'(dataOut1), 128'(32'hC0C1C2C3));
    cmp("mrst.c_msw0", 128'(dataOut0), 128'(32'hCCCDCECF));
    repeat (4) @(negedge clock);

    // Randomized run
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      dataIn    = {$urandom, $urandom, $urandom, $urandom};
      out_ready = (i % 1000 < 300) ? 1'b1 : ($urandom_range(0, 4) != 0);
      enable    = ($urandom_range(0, 9) != 0);
      reset     = ($urandom_range(0, 249) != 0);
      @(negedge clock);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
